fuzz_response_monitor: RTL and testbench

//   Receiving end of the fuzz stimulus/response path: samples the DUT output bus y once per clock.

---
 rtl/fuzz_mon_pkg.sv | 25 ++
 rtl/fuzz_misr.sv | 40 ++++
 rtl/fuzz_response_monitor.sv | 153 +++++++++++++++
 tb/tb_fuzz_response_monitor.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fuzz_mon_pkg.sv
// Shared types and helpers for the fuzz response monitor: FSM state encoding,
// default MISR constants and a width-generic saturating increment.
package fuzz_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mon_state_e;

  localparam int DEF_WIDTH = 127;
  localparam logic [DEF_WIDTH-1:0] DEF_POLY = {{(DEF_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DEF_WIDTH-1:0] DEF_SEED = {DEF_WIDTH{1'b1}};

  localparam int SAT_W = 64;

  // Saturates at the all-ones value of a counter that is 'width' bits wide.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] val,
                                               input int              width);
    logic [SAT_W-1:0] max_v;
    max_v = (width >= SAT_W) ? '1 : ((SAT_W'(1) << width) - SAT_W'(1));
    return (val >= max_v) ? val : (val + SAT_W'(1));
  endfunction

endpackage

// File: rtl/fuzz_misr.sv
// Multiple-input signature register: shifts left with polynomial feedback from
// the MSB and folds one response word in per enabled cycle.
module fuzz_misr
  import fuzz_mon_pkg::*;
#(
  parameter int              WIDTH = DEF_WIDTH,
  parameter logic [WIDTH-1:0] POLY = DEF_POLY,
  parameter logic [WIDTH-1:0] SEED = DEF_SEED
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             shift_en_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] sig_o
);

  logic [WIDTH-1:0] sig_q;
  logic [WIDTH-1:0] sig_d;

  always_comb begin
    sig_d = sig_q;
    if (load_i) begin
      sig_d = SEED;
    end else if (shift_en_i) begin
      sig_d = ({sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0)) ^ din_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sig_q <= SEED;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/fuzz_response_monitor.sv
// Fuzz response monitor: compacts sampled DUT outputs into a MISR signature,
// compares against golden values, and records mismatch count and first failure.
//   state   | meaning
//   IDLE    | no run active, results hold
//   RUN     | accepting samples until NUM_VECTORS have been taken
//   DONE    | run complete, verdict and signature stable
module fuzz_response_monitor
  import fuzz_mon_pkg::*;
#(
  parameter int              WIDTH       = DEF_WIDTH,
  parameter int              NUM_VECTORS = 22,
  parameter int              CNT_W       = 16,
  parameter logic [WIDTH-1:0] POLY       = DEF_POLY,
  parameter logic [WIDTH-1:0] SEED       = DEF_SEED
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             sample_en_i,
  input  logic [WIDTH-1:0] y_i,
  input  logic             exp_valid_i,
  input  logic [WIDTH-1:0] exp_y_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [WIDTH-1:0] signature_o,
  output logic [CNT_W-1:0] sample_count_o,
  output logic [CNT_W-1:0] mismatch_count_o,
  output logic [CNT_W-1:0] first_fail_idx_o,
  output logic [WIDTH-1:0] first_fail_y_o
);

  // The sample counter must be able to hold NUM_VECTORS without wrapping.
  if (WIDTH < 2 || CNT_W < 1 || CNT_W > 62 || NUM_VECTORS < 1 ||
      longint'(NUM_VECTORS) > ((longint'(1) << CNT_W) - longint'(1))) begin : g_cfg_bad
    $error("fuzz_response_monitor: NUM_VECTORS=%0d does not fit CNT_W=%0d (WIDTH=%0d)",
           NUM_VECTORS, CNT_W, WIDTH);
  end

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECTORS - 1);

  mon_state_e       state_q, state_d;
  logic [CNT_W-1:0] sample_count_q, sample_count_d;
  logic [CNT_W-1:0] mismatch_count_q, mismatch_count_d;
  logic [CNT_W-1:0] first_fail_idx_q, first_fail_idx_d;
  logic [WIDTH-1:0] first_fail_y_q, first_fail_y_d;
  logic             fail_seen_q, fail_seen_d;

  logic             load_sig;
  logic             accept;
  logic             mismatch;

  always_comb begin
    state_d  = state_q;
    load_sig = 1'b0;
    accept   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!abort_i && start_i) begin
          state_d  = ST_RUN;
          load_sig = 1'b1;
        end
      end
      ST_RUN: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (sample_en_i) begin
          accept = 1'b1;
          if (sample_count_q == LAST_IDX) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (start_i) begin
          state_d  = ST_RUN;
          load_sig = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mismatch = accept && exp_valid_i && (y_i != exp_y_i);

  always_comb begin
    sample_count_d   = sample_count_q;
    mismatch_count_d = mismatch_count_q;
    first_fail_idx_d = first_fail_idx_q;
    first_fail_y_d   = first_fail_y_q;
    fail_seen_d      = fail_seen_q;
    if (load_sig) begin
      sample_count_d   = '0;
      mismatch_count_d = '0;
      first_fail_idx_d = '0;
      first_fail_y_d   = '0;
      fail_seen_d      = 1'b0;
    end else if (accept) begin
      sample_count_d = sample_count_q + CNT_W'(1);
      if (mismatch) begin
        mismatch_count_d = CNT_W'(sat_inc(SAT_W'(mismatch_count_q), CNT_W));
        if (!fail_seen_q) begin
          first_fail_idx_d = sample_count_q;
          first_fail_y_d   = y_i;
          fail_seen_d      = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q          <= ST_IDLE;
      sample_count_q   <= '0;
      mismatch_count_q <= '0;
      first_fail_idx_q <= '0;
      first_fail_y_q   <= '0;
      fail_seen_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      sample_count_q   <= sample_count_d;
      mismatch_count_q <= mismatch_count_d;
      first_fail_idx_q <= first_fail_idx_d;
      first_fail_y_q   <= first_fail_y_d;
      fail_seen_q      <= fail_seen_d;
    end
  end

  fuzz_misr #(
    .WIDTH (WIDTH),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (load_sig),
    .shift_en_i (accept),
    .din_i      (y_i),
    .sig_o      (signature_o)
  );

  assign busy_o           = (state_q == ST_RUN);
  assign done_o           = (state_q == ST_DONE);
  assign pass_o           = (state_q == ST_DONE) && (mismatch_count_q == '0);
  assign sample_count_o   = sample_count_q;
  assign mismatch_count_o = mismatch_count_q;
  assign first_fail_idx_o = first_fail_idx_q;
  assign first_fail_y_o   = first_fail_y_q;

endmodule

// File: tb/tb_fuzz_response_monitor.sv
// Scoreboard bench for fuzz_response_monitor: a reference model predicts every
// cycle's outputs into a queue; a negedge monitor pops and compares.
module tb_fuzz_response_monitor;

  localparam int W  = 8;
  localparam int NV = 4;
  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, abort, sample_en, exp_valid;
  logic [W-1:0]  y, exp_y;
  logic          busy, done, pass;
  logic [W-1:0]  signature, first_fail_y;
  logic [CW-1:0] sample_count, mismatch_count, first_fail_idx;

  fuzz_response_monitor #(
    .WIDTH       (W),
    .NUM_VECTORS (NV),
    .CNT_W       (CW),
    .POLY        (8'h1D),
    .SEED        (8'hFF)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .start_i          (start),
    .abort_i          (abort),
    .sample_en_i      (sample_en),
    .y_i              (y),
    .exp_valid_i      (exp_valid),
    .exp_y_i          (exp_y),
    .busy_o           (busy),
    .done_o           (done),
    .pass_o           (pass),
    .signature_o      (signature),
    .sample_count_o   (sample_count),
    .mismatch_count_o (mismatch_count),
    .first_fail_idx_o (first_fail_idx),
    .first_fail_y_o   (first_fail_y)
  );

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          pass;
    logic [W-1:0]  sig;
    logic [CW-1:0] cnt;
    logic [CW-1:0] mm;
    logic [CW-1:0] ffi;
    logic [W-1:0]  ffy;
  } snap_t;

  snap_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: run phase (0 idle, 1 collecting, 2 finished) plus results.
  int           m_phase = 0;
  logic [W-1:0] m_sig   = 8'hFF;
  int           m_cnt   = 0;
  int           m_mm    = 0;
  int           m_ffi   = 0;
  logic [W-1:0] m_ffy   = '0;
  bit           m_seen  = 1'b0;

  function automatic logic [W-1:0] misr_next(input logic [W-1:0] s, input logic [W-1:0] d);
    logic [W:0] t;
    t = {s, 1'b0};
    if (t[W]) t = t ^ 9'h11D;  // reduce modulo x^8+x^4+x^3+x^2+1
    return t[W-1:0] ^ d;
  endfunction

  task automatic model_step(input bit r, input bit st, input bit ab, input bit se,
                            input bit ev, input logic [W-1:0] yy, input logic [W-1:0] ey);
    snap_t e;
    if (r) begin
      m_phase = 0; m_sig = 8'hFF; m_cnt = 0; m_mm = 0; m_ffi = 0; m_ffy = '0; m_seen = 0;
    end else if (ab) begin
      m_phase = 0;
    end else if (st && m_phase != 1) begin
      m_phase = 1; m_sig = 8'hFF; m_cnt = 0; m_mm = 0; m_ffi = 0; m_ffy = '0; m_seen = 0;
    end else if (m_phase == 1 && se) begin
      m_sig = misr_next(m_sig, yy);
      if (ev && yy != ey) begin
        if (m_mm < 65535) m_mm++;
        if (!m_seen) begin
          m_seen = 1; m_ffi = m_cnt; m_ffy = yy;
        end
      end
      m_cnt++;
      if (m_cnt == NV) m_phase = 2;
    end
    e.busy = (m_phase == 1);
    e.done = (m_phase == 2);
    e.pass = (m_phase == 2) && (m_mm == 0);
    e.sig  = m_sig;
    e.cnt  = CW'(m_cnt);
    e.mm   = CW'(m_mm);
    e.ffi  = CW'(m_ffi);
    e.ffy  = m_ffy;
    exp_q.push_back(e);
  endtask

  task automatic step(input bit r, input bit st, input bit ab, input bit se,
                      input bit ev, input logic [W-1:0] yy, input logic [W-1:0] ey);
    rst = r; start = st; abort = ab; sample_en = se; exp_valid = ev; y = yy; exp_y = ey;
    @(posedge clk);
    model_step(r, st, ab, se, ev, yy, ey);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, '0, '0);
  endtask

  task automatic go();
    step(0, 1, 0, 0, 0, '0, '0);
  endtask

  task automatic smp(input logic [W-1:0] yy, input logic [W-1:0] ey);
    step(0, 0, 0, 1, 1, yy, ey);
  endtask

  always @(negedge clk) begin
    snap_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("busy",           32'(busy),           32'(e.busy));
      chk("done",           32'(done),           32'(e.done));
      chk("pass",           32'(pass),           32'(e.pass));
      chk("signature",      32'(signature),      32'(e.sig));
      chk("sample_count",   32'(sample_count),   32'(e.cnt));
      chk("mismatch_count", 32'(mismatch_count), 32'(e.mm));
      chk("first_fail_idx", 32'(first_fail_idx), 32'(e.ffi));
      chk("first_fail_y",   32'(first_fail_y),   32'(e.ffy));
    end
  end

  initial begin
    logic [W-1:0] v;
    int guard;
    rst = 1; start = 0; abort = 0; sample_en = 0; exp_valid = 0; y = '0; exp_y = '0;
    step(1, 0, 0, 0, 0, '0, '0);
    step(1, 1, 0, 1, 1, 8'h12, 8'h34);
    idle();
    chk("rst_sig", 32'(signature), 32'h00FF);

    // start cycle sample is ignored; first real sample y=00 gives E3
    step(0, 1, 0, 1, 1, 8'h55, 8'h00);
    smp(8'h00, 8'h00);
    chk("t1_sig", 32'(signature), 32'h00E3);
    chk("t1_cnt", 32'(sample_count), 32'd1);
    chk("t1_busy", 32'(busy), 32'd1);

    go();
    for (int i = 0; i < NV; i++) begin
      v = 8'($urandom);
      smp(v, v);
    end
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_pass", 32'(pass), 32'd1);
    smp(8'h77, 8'h00);
    smp(8'h99, 8'h99);

    go();
    smp(8'h10, 8'h10);
    step(0, 0, 0, 1, 0, 8'h20, 8'h00);
    smp(8'hA5, 8'hA4);
    smp(8'h3C, 8'h3C);
    chk("t3_mm", 32'(mismatch_count), 32'd1);
    chk("t3_ffi", 32'(first_fail_idx), 32'd2);
    chk("t3_ffy", 32'(first_fail_y), 32'h00A5);
    chk("t3_pass", 32'(pass), 32'd0);

    go();
    smp(8'h01, 8'h01);
    smp(8'h02, 8'h03);
    step(0, 1, 1, 1, 1, 8'h04, 8'h05);
    chk("t4_cnt", 32'(sample_count), 32'd2);
    chk("t4_busy", 32'(busy), 32'd0);
    go();
    chk("t4_sig", 32'(signature), 32'h00FF);

    smp(8'hC3, 8'hC2);
    smp(8'h5A, 8'h5A);
    step(1, 0, 0, 1, 1, 8'hEE, 8'h11);
    chk("t5_sig", 32'(signature), 32'h00FF);
    chk("t5_mm", 32'(mismatch_count), 32'd0);
    go();
    for (int i = 0; i < NV; i++) smp(8'(i * 37 + 5), 8'(i * 37 + 4));
    step(0, 1, 0, 1, 1, 8'h00, 8'h01);
    chk("t5_rerun_cnt", 32'(sample_count), 32'd0);
    chk("t5_rerun_busy", 32'(busy), 32'd1);

    for (int i = 0; i < 600; i++) begin
      bit r, st, ab, se, ev;
      logic [W-1:0] yy, ey;
      r  = ($urandom_range(0, 99) < 2);
      st = ($urandom_range(0, 99) < 12);
      ab = ($urandom_range(0, 99) < 3);
      se = ($urandom_range(0, 99) < 65);
      ev = ($urandom_range(0, 99) < 70);
      yy = 8'($urandom);
      ey = ($urandom_range(0, 3) == 0) ? (yy ^ (8'h01 << $urandom_range(0, 7))) : yy;
      step(r, st, ab, se, ev, yy, ey);
    end

    repeat (3) idle();
    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    #1;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: actual %0d pending required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
